// File: rtl/axi_stream_input_sram_writer.sv
// AXI4-Stream slave that streams a row*col tensor into the input SRAM at consecutive
// addresses from a base, with a tlast framing check against the expected element count.
module axi_stream_input_sram_writer #(
    parameter int ADDR_WIDTH         = 13,
    parameter int DATA_WIDTH         = 8,
    parameter int NUM_CHANNELS_WIDTH = $clog2(64 + 1)
) (
    input  logic                          s_axis_aclk,
    input  logic                          s_axis_areset,
    input  logic [DATA_WIDTH-1:0]         s_axis_tdata,
    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready,
    input  logic                          s_axis_tlast,
    input  logic [NUM_CHANNELS_WIDTH-1:0] s_axis_tuser,
    output logic                          sram_in_en,
    output logic                          sram_in_we,
    output logic [ADDR_WIDTH-1:0]         sram_in_addr,
    output logic [DATA_WIDTH-1:0]         sram_in_data,
    input  logic                          start_input,
    input  logic [ADDR_WIDTH-1:0]         base_addr,
    input  logic [ADDR_WIDTH-1:0]         in_row,
    input  logic [ADDR_WIDTH-1:0]         in_col,
    output logic                          input_done,
    output logic                          frame_err,
    output logic [NUM_CHANNELS_WIDTH-1:0] channel_tag
);

    localparam int CNT_WIDTH = 2 * ADDR_WIDTH;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [ADDR_WIDTH-1:0] base_q;
    logic [CNT_WIDTH-1:0]  total_q;
    logic [CNT_WIDTH-1:0]  total_start;
    logic [CNT_WIDTH-1:0]  cnt;
    logic                  beat_accept;
    logic                  last_by_count;

    assign total_start   = CNT_WIDTH'(in_row) * CNT_WIDTH'(in_col);
    assign s_axis_tready = (state == RECV);
    assign beat_accept   = s_axis_tvalid && s_axis_tready;
    assign last_by_count = (cnt == (total_q - CNT_ONE));

    always_ff @(posedge s_axis_aclk) begin
        if (s_axis_areset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // An early tlast ends the frame just like reaching the expected count.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start_input) begin
                    state_next = (total_start == '0) ? DONE : RECV;
                end
            end
            RECV: begin
                if (beat_accept && (last_by_count || s_axis_tlast)) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Writes trail the accepted beat by one cycle; the done pulse trails DONE by one.
    always_ff @(posedge s_axis_aclk) begin
        if (s_axis_areset) begin
            base_q       <= '0;
            total_q      <= '0;
            cnt          <= '0;
            sram_in_en   <= 1'b0;
            sram_in_we   <= 1'b0;
            sram_in_addr <= '0;
            sram_in_data <= '0;
            input_done   <= 1'b0;
            frame_err    <= 1'b0;
            channel_tag  <= '0;
        end else begin
            sram_in_en <= 1'b0;
            sram_in_we <= 1'b0;
            input_done <= (state == DONE);
            if (state == IDLE && start_input) begin
                base_q    <= base_addr;
                total_q   <= total_start;
                cnt       <= '0;
                frame_err <= 1'b0;
            end
            if (beat_accept) begin
                sram_in_en   <= 1'b1;
                sram_in_we   <= 1'b1;
                sram_in_addr <= base_q + cnt[ADDR_WIDTH-1:0];
                sram_in_data <= s_axis_tdata;
                cnt          <= cnt + CNT_ONE;
                if (cnt == '0) begin
                    channel_tag <= s_axis_tuser;
                end
                if (last_by_count != s_axis_tlast) begin
                    frame_err <= 1'b1;
                end
            end
        end
    end

endmodule
